// File: rtl/sdram_pkg.sv
// Shared command encoding, bank state and mode-register field layout for the
// SDRAM command responder.
package sdram_pkg;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_ACT = 4'd1,
        CMD_RD  = 4'd2,
        CMD_WR  = 4'd3,
        CMD_PRE = 4'd4,
        CMD_REF = 4'd5,
        CMD_BST = 4'd6,
        CMD_MRS = 4'd7
    } cmd_t;

    typedef enum logic {
        B_IDLE   = 1'b0,
        B_ACTIVE = 1'b1
    } bank_state_t;

    localparam int         NUM_BANKS   = 4;
    localparam int         PRE_ALL_BIT = 10;
    localparam int         MR_BL_LSB   = 0;
    localparam int         MR_BL_MSB   = 2;
    localparam int         MR_CL_LSB   = 4;
    localparam int         MR_CL_MSB   = 6;
    localparam logic [2:0] CL_MIN      = 3'd2;
    localparam logic [2:0] CL_MAX      = 3'd3;
    localparam logic [2:0] BL_CODE_MAX = 3'd3;
    localparam logic [6:0] MODE_RST    = 7'h20;

    // BL code 0..3 -> 1/2/4/8 beats
    function automatic logic [3:0] bl_beats(input logic [2:0] code);
        return 4'd1 << code[1:0];
    endfunction

endpackage

// File: rtl/sdram_bank_tracker.sv
// One bank's open/closed state and the row latched by its last ACT.
module sdram_bank_tracker
    import sdram_pkg::*;
#(
    parameter int ROW_W = 13
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             i_act,
    input  logic             i_pre,
    input  logic             i_pre_all,
    input  logic [ROW_W-1:0] i_row,
    output bank_state_t      o_state,
    output logic [ROW_W-1:0] o_row
);

    bank_state_t      r_state;
    logic [ROW_W-1:0] r_row;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= B_IDLE;
            r_row   <= '0;
        end else if (i_act && r_state == B_IDLE) begin
            r_state <= B_ACTIVE;
            r_row   <= i_row;
        end else if (i_pre || i_pre_all) begin
            r_state <= B_IDLE;
        end
    end

    assign o_state = r_state;
    assign o_row   = r_row;

endmodule

// File: rtl/sdram_cmd_responder.sv
// Device-side SDRAM command decoder: bank tracking, mode register, refresh
// timer, burst sequencing onto a storage port and a CAS-latency read pipe.
module sdram_cmd_responder
    import sdram_pkg::*;
#(
    parameter int ROW_W  = 13,
    parameter int COL_W  = 9,
    parameter int DATA_W = 16,
    parameter int T_RFC  = 7
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  cmd_t                      command,
    input  logic [ROW_W-1:0]          addr,
    input  logic [1:0]                ba,
    input  logic [DATA_W-1:0]         dq_in,
    output logic [DATA_W-1:0]         dq_out,
    output logic                      dq_valid,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [2+ROW_W+COL_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [6:0]                mode_reg,
    output logic                      busy,
    output logic                      cmd_err
);

    localparam int RFC_W = $clog2(T_RFC + 1);

    bank_state_t      w_bank_state [NUM_BANKS];
    logic [ROW_W-1:0] w_bank_row   [NUM_BANKS];
    logic             w_all_idle, w_act, w_pre, w_start, w_bst, w_ref, w_mrs, w_err, w_stop;
    logic [COL_W-1:0] w_mask;

    logic [6:0]        r_mode;
    logic [RFC_W-1:0]  r_rfc_cnt;
    logic              r_cmd_err;
    logic              r_burst, r_we;
    logic [1:0]        r_bank;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [2:0]        r_left;
    logic [DATA_W-1:0] r_wdata;
    logic              r_p1_vld, r_p2_vld;
    logic [DATA_W-1:0] r_p1_data, r_p2_data;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        sdram_bank_tracker #(.ROW_W(ROW_W)) u_trk (
            .clk       (clk),
            .n_rst     (n_rst),
            .i_act     (w_act && ba == 2'(g)),
            .i_pre     (w_pre && ba == 2'(g)),
            .i_pre_all (w_pre && addr[PRE_ALL_BIT]),
            .i_row     (addr),
            .o_state   (w_bank_state[g]),
            .o_row     (w_bank_row[g])
        );
    end

    assign busy   = |r_rfc_cnt;
    assign w_mask = COL_W'(bl_beats(r_mode[MR_BL_MSB:MR_BL_LSB]) - 4'd1);

    // Legality is judged against state before the edge; illegal commands only raise cmd_err.
    always_comb begin
        w_all_idle = 1'b1;
        for (int i = 0; i < NUM_BANKS; i++)
            if (w_bank_state[i] != B_IDLE) w_all_idle = 1'b0;
        w_act   = 1'b0;
        w_pre   = 1'b0;
        w_start = 1'b0;
        w_bst   = 1'b0;
        w_ref   = 1'b0;
        w_mrs   = 1'b0;
        w_err   = 1'b0;
        if (busy) begin
            w_err = (command != CMD_NOP);
        end else begin
            case (command)
                CMD_NOP: ;
                CMD_ACT: if (w_bank_state[ba] == B_ACTIVE) w_err = 1'b1; else w_act = 1'b1;
                CMD_RD,
                CMD_WR:  if (w_bank_state[ba] != B_ACTIVE) w_err = 1'b1; else w_start = 1'b1;
                CMD_PRE: w_pre = 1'b1;
                CMD_REF: if (!w_all_idle) w_err = 1'b1; else w_ref = 1'b1;
                CMD_BST: if (!r_burst) w_err = 1'b1; else w_bst = 1'b1;
                CMD_MRS: begin
                    if (!w_all_idle || r_burst || r_p1_vld || r_p2_vld ||
                        !(addr[MR_CL_MSB:MR_CL_LSB] == CL_MIN || addr[MR_CL_MSB:MR_CL_LSB] == CL_MAX) ||
                        addr[MR_BL_MSB:MR_BL_LSB] > BL_CODE_MAX)
                        w_err = 1'b1;
                    else
                        w_mrs = 1'b1;
                end
                default: w_err = 1'b1;
            endcase
        end
        w_stop = w_bst || (w_pre && r_burst && (addr[PRE_ALL_BIT] || ba == r_bank));
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_mode    <= MODE_RST;
            r_rfc_cnt <= '0;
            r_cmd_err <= 1'b0;
            r_wdata   <= '0;
        end else begin
            r_cmd_err <= w_err;
            r_wdata   <= dq_in;
            if (w_mrs) r_mode <= addr[6:0];
            if (w_ref)
                r_rfc_cnt <= RFC_W'(T_RFC);
            else if (busy)
                r_rfc_cnt <= r_rfc_cnt - RFC_W'(1);
        end
    end

    // A new RD/WR wins over termination and simply replaces the running burst.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_burst <= 1'b0;
            r_we    <= 1'b0;
            r_bank  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_left  <= '0;
        end else if (w_start) begin
            r_burst <= 1'b1;
            r_we    <= (command == CMD_WR);
            r_bank  <= ba;
            r_row   <= w_bank_row[ba];
            r_col   <= addr[COL_W-1:0];
            r_left  <= 3'(bl_beats(r_mode[MR_BL_MSB:MR_BL_LSB]) - 4'd1);
        end else if (w_stop) begin
            r_burst <= 1'b0;
        end else if (r_burst) begin
            if (r_left == 3'd0) begin
                r_burst <= 1'b0;
            end else begin
                r_left <= r_left - 3'd1;
                r_col  <= (r_col & ~w_mask) | ((r_col + COL_W'(1)) & w_mask);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_p1_vld  <= 1'b0;
            r_p1_data <= '0;
            r_p2_vld  <= 1'b0;
            r_p2_data <= '0;
        end else begin
            r_p1_vld  <= r_burst && !r_we;
            r_p1_data <= (r_burst && !r_we) ? mem_rdata : '0;
            r_p2_vld  <= r_p1_vld;
            r_p2_data <= r_p1_data;
        end
    end

    // CL=2 returns from the first pipe stage, CL=3 from the second.
    assign dq_valid  = (r_mode[MR_CL_MSB:MR_CL_LSB] == CL_MAX) ? r_p2_vld : r_p1_vld;
    assign dq_out    = (r_mode[MR_CL_MSB:MR_CL_LSB] == CL_MAX) ? r_p2_data : r_p1_data;
    assign mem_en    = r_burst;
    assign mem_we    = r_burst && r_we;
    assign mem_addr  = r_burst ? {r_bank, r_row, r_col} : '0;
    assign mem_wdata = (r_burst && r_we) ? r_wdata : '0;
    assign mode_reg  = r_mode;
    assign cmd_err   = r_cmd_err;

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Directed bench: table of single-command vectors, then hand sequences for
// burst read, truncation, refresh timing and reset mid-read.
module tb_sdram_cmd_responder;
    import sdram_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    cmd_t        command = CMD_NOP;
    logic [12:0] addr = '0;
    logic [1:0]  ba = '0;
    logic [15:0] dq_in = '0;
    logic [15:0] dq_out, mem_wdata, mem_rdata;
    logic        dq_valid, mem_en, mem_we, busy, cmd_err;
    logic [23:0] mem_addr;
    logic [6:0]  mode_reg;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] mdl(input logic [23:0] a);
        return a[15:0] ^ {a[23:16], 8'h5A};
    endfunction

    assign mem_rdata = mdl(mem_addr);

    sdram_cmd_responder dut (
        .clk(clk), .n_rst(n_rst), .command(command), .addr(addr), .ba(ba),
        .dq_in(dq_in), .dq_out(dq_out), .dq_valid(dq_valid), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mode_reg(mode_reg), .busy(busy), .cmd_err(cmd_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [12:0] a, input logic [1:0] b, input logic [15:0] d);
        command = cmd_t'(c);
        addr    = a;
        ba      = b;
        dq_in   = d;
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]  cmd;
        logic [12:0] addr;
        logic [1:0]  ba;
        logic [15:0] dq;
        logic        err;
        logic [6:0]  mode;
        logic        en;
        logic        we;
        logic [23:0] maddr;
        logic [15:0] wdata;
    } vec_t;

    vec_t vt[17];
    logic [15:0] got[$];
    logic [15:0] exp_q[$];
    logic [23:0] ea;
    logic [8:0]  cols_a[4];
    logic [8:0]  cols_b[11];

    initial begin
        vt[0]  = '{4'd7, 13'h020, 2'd0, 16'h0,    1'b0, 7'h20, 1'b0, 1'b0, 24'h0, 16'h0};
        vt[1]  = '{4'd7, 13'h050, 2'd0, 16'h0,    1'b1, 7'h20, 1'b0, 1'b0, 24'h0, 16'h0};
        vt[2]  = '{4'd0, 13'h000, 2'd0, 16'h0,    1'b0, 7'h20, 1'b0, 1'b0, 24'h0, 16'h0};
        vt[3]  = '{4'd7, 13'h024, 2'd0, 16'h0,    1'b1, 7'h20, 1'b0, 1'b0, 24'h0, 16'h0};
        vt[4]  = '{4'd7, 13'h007, 2'd0, 16'h0,    1'b1, 7'h20, 1'b0, 1'b0, 24'h0, 16'h0};
        vt[5]  = '{4'd1, 13'h005, 2'd1, 16'h0,    1'b0, 7'h20, 1'b0, 1'b0, 24'h0, 16'h0};
        vt[6]  = '{4'd3, 13'h003, 2'd1, 16'hABCD, 1'b0, 7'h20, 1'b1, 1'b1, {2'd1, 13'd5, 9'd3}, 16'hABCD};
        vt[7]  = '{4'd0, 13'h000, 2'd0, 16'h0,    1'b0, 7'h20, 1'b0, 1'b0, 24'h0, 16'h0};
        vt[8]  = '{4'd1, 13'h007, 2'd1, 16'h0,    1'b1, 7'h20, 1'b0, 1'b0, 24'h0, 16'h0};
        vt[9]  = '{4'd2, 13'h001, 2'd2, 16'h0,    1'b1, 7'h20, 1'b0, 1'b0, 24'h0, 16'h0};
        vt[10] = '{4'd6, 13'h000, 2'd0, 16'h0,    1'b1, 7'h20, 1'b0, 1'b0, 24'h0, 16'h0};
        vt[11] = '{4'd9, 13'h000, 2'd0, 16'h0,    1'b1, 7'h20, 1'b0, 1'b0, 24'h0, 16'h0};
        vt[12] = '{4'd5, 13'h000, 2'd0, 16'h0,    1'b1, 7'h20, 1'b0, 1'b0, 24'h0, 16'h0};
        vt[13] = '{4'd7, 13'h032, 2'd0, 16'h0,    1'b1, 7'h20, 1'b0, 1'b0, 24'h0, 16'h0};
        vt[14] = '{4'd4, 13'h000, 2'd1, 16'h0,    1'b0, 7'h20, 1'b0, 1'b0, 24'h0, 16'h0};
        vt[15] = '{4'd2, 13'h003, 2'd1, 16'h0,    1'b1, 7'h20, 1'b0, 1'b0, 24'h0, 16'h0};
        vt[16] = '{4'd7, 13'h032, 2'd0, 16'h0,    1'b0, 7'h32, 1'b0, 1'b0, 24'h0, 16'h0};
        cols_a = '{9'd6, 9'd7, 9'd4, 9'd5};
        cols_b = '{9'd8, 9'd9, 9'd10, 9'd21, 9'd22, 9'd23, 9'd16, 9'd17, 9'd18, 9'd19, 9'd20};

        // Reset state
        #12;
        chk("rst_mode", 32'(mode_reg), 32'h20);
        chk("rst_err", 32'(cmd_err), 0);
        chk("rst_en", 32'(mem_en), 0);
        chk("rst_dqv", 32'(dq_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        n_rst = 1'b1;
        cyc();

        for (int i = 0; i < 17; i++) begin
            drive(vt[i].cmd, vt[i].addr, vt[i].ba, vt[i].dq);
            cyc();
            chk($sformatf("v%0d_err", i), 32'(cmd_err), 32'(vt[i].err));
            chk($sformatf("v%0d_mode", i), 32'(mode_reg), 32'(vt[i].mode));
            chk($sformatf("v%0d_en", i), 32'(mem_en), 32'(vt[i].en));
            if (vt[i].en) begin
                chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(vt[i].we));
                chk($sformatf("v%0d_maddr", i), 32'(mem_addr), 32'(vt[i].maddr));
                chk($sformatf("v%0d_wdata", i), 32'(mem_wdata), 32'(vt[i].wdata));
            end
        end

        // CL3 BL4 read, wrapping column order 6,7,4,5
        drive(4'd1, 13'd9, 2'd2, 16'h0);
        cyc();
        chk("a_act_err", 32'(cmd_err), 0);
        drive(4'd2, 13'd6, 2'd2, 16'h0);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            drive(4'd0, 13'd0, 2'd0, 16'h0);
            chk($sformatf("a_en%0d", i), 32'(mem_en), 32'(i <= 4));
            if (i <= 4) begin
                chk($sformatf("a_we%0d", i), 32'(mem_we), 0);
                chk($sformatf("a_addr%0d", i), 32'(mem_addr), 32'({2'd2, 13'd9, cols_a[i-1]}));
            end
            chk($sformatf("a_dqv%0d", i), 32'(dq_valid), 32'(i >= 3 && i <= 6));
            if (i >= 3 && i <= 6) begin
                ea = {2'd2, 13'd9, cols_a[i-3]};
                chk($sformatf("a_dq%0d", i), 32'(dq_out), 32'(mdl(ea)));
            end
        end

        // CL2 BL8 read truncated after 3 beats by a second read
        drive(4'd4, 13'h400, 2'd0, 16'h0);
        cyc();
        drive(4'd7, 13'h023, 2'd0, 16'h0);
        cyc();
        chk("b_mrs_err", 32'(cmd_err), 0);
        chk("b_mode", 32'(mode_reg), 32'h23);
        drive(4'd1, 13'd3, 2'd0, 16'h0);
        cyc();
        for (int i = 0; i < 16; i++) begin
            if (i == 0)      drive(4'd2, 13'd8, 2'd0, 16'h0);
            else if (i == 3) drive(4'd2, 13'd21, 2'd0, 16'h0);
            else             drive(4'd0, 13'd0, 2'd0, 16'h0);
            cyc();
            if (dq_valid) got.push_back(dq_out);
        end
        for (int i = 0; i < 11; i++) begin
            ea = {2'd0, 13'd3, cols_b[i]};
            exp_q.push_back(mdl(ea));
        end
        chk("b_count", 32'(got.size()), 11);
        for (int i = 0; i < 11 && i < got.size(); i++)
            chk($sformatf("b_beat%0d", i), 32'(got[i]), 32'(exp_q[i]));

        // Refresh: rejected with a bank open, then 7 busy cycles
        drive(4'd5, 13'd0, 2'd0, 16'h0);
        cyc();
        chk("c_ref_open_err", 32'(cmd_err), 1);
        drive(4'd4, 13'h400, 2'd0, 16'h0);
        cyc();
        drive(4'd5, 13'd0, 2'd0, 16'h0);
        for (int j = 1; j <= 8; j++) begin
            cyc();
            chk($sformatf("c_busy%0d", j), 32'(busy), 32'(j <= 7));
            chk($sformatf("c_err%0d", j), 32'(cmd_err), 32'(j == 4));
            if (j == 3) drive(4'd1, 13'd2, 2'd0, 16'h0);
            else        drive(4'd0, 13'd0, 2'd0, 16'h0);
        end
        drive(4'd1, 13'd2, 2'd0, 16'h0);
        cyc();
        chk("c_act_after", 32'(cmd_err), 0);

        // Reset in the middle of a CL3 read
        drive(4'd4, 13'h400, 2'd0, 16'h0);
        cyc();
        drive(4'd7, 13'h033, 2'd0, 16'h0);
        cyc();
        chk("d_mode", 32'(mode_reg), 32'h33);
        drive(4'd1, 13'd1, 2'd3, 16'h0);
        cyc();
        drive(4'd2, 13'd0, 2'd3, 16'h0);
        cyc();
        drive(4'd0, 13'd0, 2'd0, 16'h0);
        cyc();
        cyc();
        chk("d_dqv_pre", 32'(dq_valid), 1);
        n_rst = 1'b0;
        #1;
        chk("d_dqv_rst", 32'(dq_valid), 0);
        chk("d_en_rst", 32'(mem_en), 0);
        chk("d_mode_rst", 32'(mode_reg), 32'h20);
        cyc();
        n_rst = 1'b1;
        drive(4'd2, 13'd0, 2'd3, 16'h0);
        cyc();
        chk("d_rd_idle_err", 32'(cmd_err), 1);
        drive(4'd1, 13'd1, 2'd3, 16'h0);
        cyc();
        chk("d_act_err", 32'(cmd_err), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
